// File: rtl/spu_pkg.sv
// spu_pkg: shared types and constants for the SPU issue scoreboard
package spu_pkg;
  localparam int NUM_REGS = 128;
  localparam int REG_W = 7;
  localparam int LAT_W = 4;
  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0] lat_t;
  typedef logic [2:0] src_use_t;
  typedef logic [3*REG_W-1:0] src_t;
  // source-use masks by instruction format, bit order {rc,rb,ra}
  localparam src_use_t USE_RR = 3'b011;
  localparam src_use_t USE_RRR = 3'b111;
  localparam src_use_t USE_RI7 = 3'b001;
  localparam src_use_t USE_RI10 = 3'b001;
  localparam src_use_t USE_RI16 = 3'b000;
  localparam src_use_t USE_RI18 = 3'b000;
endpackage

// File: rtl/spu_issue_scoreboard_if.sv
// spu_issue_scoreboard_if: decoder <-> scoreboard issue handshake
interface spu_issue_scoreboard_if;
  import spu_pkg::*;
  logic flush;
  logic ev_valid;
  reg_idx_t ev_rt;
  lat_t ev_lat;
  src_t ev_src;
  src_use_t ev_src_use;
  logic od_valid;
  reg_idx_t od_rt;
  lat_t od_lat;
  src_t od_src;
  src_use_t od_src_use;
  logic ev_issue;
  logic od_issue;
  logic stall;
  logic [NUM_REGS-1:0] busy_vec;
  modport master(
    output flush, ev_valid, ev_rt, ev_lat, ev_src, ev_src_use,
    output od_valid, od_rt, od_lat, od_src, od_src_use,
    input ev_issue, od_issue, stall, busy_vec
  );
  modport slave(
    input flush, ev_valid, ev_rt, ev_lat, ev_src, ev_src_use,
    input od_valid, od_rt, od_lat, od_src, od_src_use,
    output ev_issue, od_issue, stall, busy_vec
  );
endinterface

// File: rtl/spu_sb_hazard_check.sv
// spu_sb_hazard_check: RAW/WAW lookup of one instruction against the busy registers
module spu_sb_hazard_check
  import spu_pkg::*;
(
  input  logic [NUM_REGS-1:0] busy_vec,
  input  src_t                src,
  input  src_use_t            src_use,
  input  reg_idx_t            rt,
  input  lat_t                lat,
  output logic                raw_hit,
  output logic                waw_hit
);
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < 3; i++) raw_hit = raw_hit | (src_use[i] & busy_vec[src[i*REG_W +: REG_W]]);
  end
  assign waw_hit = (lat != '0) & busy_vec[rt];
endmodule

// File: rtl/spu_issue_scoreboard.sv
// spu_issue_scoreboard: per-register latency countdown and even/odd pair issue control
module spu_issue_scoreboard
  import spu_pkg::*;
(
  input logic clk,
  input logic reset,
  spu_issue_scoreboard_if.slave sb
);
  lat_t cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic ev_raw, ev_waw, od_raw, od_waw, intra, go, ev_go, od_go;
  spu_sb_hazard_check u_ev (
    .busy_vec(busy), .src(sb.ev_src), .src_use(sb.ev_src_use),
    .rt(sb.ev_rt), .lat(sb.ev_lat), .raw_hit(ev_raw), .waw_hit(ev_waw)
  );
  spu_sb_hazard_check u_od (
    .busy_vec(busy), .src(sb.od_src), .src_use(sb.od_src_use),
    .rt(sb.od_rt), .lat(sb.od_lat), .raw_hit(od_raw), .waw_hit(od_waw)
  );
  // odd must not read or overwrite what the older even of the same pair writes
  always_comb begin
    intra = 1'b0;
    for (int i = 0; i < 3; i++) intra = intra | (sb.od_src_use[i] & (sb.od_src[i*REG_W +: REG_W] == sb.ev_rt));
    intra = sb.ev_valid & (sb.ev_lat != '0) & (intra | ((sb.od_lat != '0) & (sb.od_rt == sb.ev_rt)));
  end
  assign go = ~reset & ~sb.flush;
  assign ev_go = go & sb.ev_valid & ~ev_raw & ~ev_waw;
  assign od_go = go & sb.od_valid & (ev_go | ~sb.ev_valid) & ~od_raw & ~od_waw & ~intra;
  assign sb.ev_issue = ev_go;
  assign sb.od_issue = od_go;
  assign sb.stall = ~reset & ((sb.ev_valid & ~ev_go) | (sb.od_valid & ~od_go));
  assign sb.busy_vec = reset ? '0 : busy;
  genvar r;
  for (r = 0; r < NUM_REGS; r++) begin : g_cnt
    assign busy[r] = cnt[r] != '0;
    always_ff @(posedge clk) begin
      if (reset || sb.flush) cnt[r] <= '0;
      else if (ev_go && sb.ev_lat != '0 && sb.ev_rt == REG_W'(r)) cnt[r] <= sb.ev_lat;
      else if (od_go && sb.od_lat != '0 && sb.od_rt == REG_W'(r)) cnt[r] <= sb.od_lat;
      else if (busy[r]) cnt[r] <= cnt[r] - 1'b1;
    end
  end
endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// tb_spu_issue_scoreboard: directed vector table plus max-latency and flush/reset sequences
module tb_spu_issue_scoreboard;
  import spu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  spu_issue_scoreboard_if ifc ();
  spu_issue_scoreboard dut (.clk(clk), .reset(reset), .sb(ifc.slave));
  always #5 clk = ~clk;
  typedef struct {
    bit r, f, evv;
    int ert, elat, era, erb;
    bit [2:0] euse;
    bit odv;
    int ort, olat, ora, orb;
    bit [2:0] ouse;
    bit xe, xo, xs;
    logic [127:0] xb;
  } vec_t;
  vec_t tv[$];
  function automatic logic [127:0] bm(int a = -1, int b = -1, int c = -1);
    logic [127:0] m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction
  task automatic add(bit r, bit f, bit evv, int ert, int elat, int era, int erb, bit [2:0] euse,
                     bit odv, int ort, int olat, int ora, int orb, bit [2:0] ouse,
                     bit xe, bit xo, bit xs, logic [127:0] xb);
    vec_t v;
    v.r = r; v.f = f; v.evv = evv; v.ert = ert; v.elat = elat; v.era = era; v.erb = erb; v.euse = euse;
    v.odv = odv; v.ort = ort; v.olat = olat; v.ora = ora; v.orb = orb; v.ouse = ouse;
    v.xe = xe; v.xo = xo; v.xs = xs; v.xb = xb;
    tv.push_back(v);
  endtask
  task automatic idle(int k, logic [127:0] xb);
    add(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, xb);
  endtask
  task automatic drive(vec_t v);
    reset = v.r;
    ifc.flush = v.f;
    ifc.ev_valid = v.evv;
    ifc.ev_rt = REG_W'(v.ert);
    ifc.ev_lat = LAT_W'(v.elat);
    ifc.ev_src = {REG_W'(v.erb), REG_W'(v.erb), REG_W'(v.era)};
    ifc.ev_src_use = v.euse;
    ifc.od_valid = v.odv;
    ifc.od_rt = REG_W'(v.ort);
    ifc.od_lat = LAT_W'(v.olat);
    ifc.od_src = {REG_W'(v.orb), REG_W'(v.orb), REG_W'(v.ora)};
    ifc.od_src_use = v.ouse;
  endtask
  task automatic chk(string name, int idx, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  initial begin
    vec_t v;
    int waits;
    add(1, 0, 1, 0, 3, 0, 0, 3'b000, 1, 1, 2, 0, 0, 3'b000, 0, 0, 0, '0);
    add(1, 0, 1, 0, 3, 0, 0, 3'b000, 1, 1, 2, 0, 0, 3'b000, 0, 0, 0, '0);
    // RAW: producer r5 lat 6, consumer waits for the counter to drain
    add(0, 0, 1, 5, 6, 0, 0, 3'b001, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, '0);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 20, 0, 5, 0, 3'b001, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, bm(5));
    add(0, 0, 1, 20, 0, 5, 0, 3'b001, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, '0);
    // intra-pair: odd reads even's destination
    add(0, 0, 1, 10, 2, 1, 0, 3'b001, 1, 11, 1, 10, 0, 3'b001, 1, 0, 1, '0);
    add(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 11, 1, 10, 0, 3'b001, 0, 0, 1, bm(10));
    add(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 11, 1, 10, 0, 3'b001, 0, 0, 1, bm(10));
    add(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 11, 1, 10, 0, 3'b001, 0, 1, 0, '0);
    // independent pair
    add(0, 0, 1, 1, 6, 3, 4, 3'b011, 1, 2, 4, 5, 0, 3'b001, 1, 1, 0, bm(11));
    idle(0, bm(1, 2));
    idle(0, bm(1, 2));
    idle(0, bm(1, 2));
    idle(0, bm(1, 2));
    idle(0, bm(1));
    idle(0, bm(1));
    idle(0, '0);
    // ordering and WAW
    add(0, 0, 1, 7, 5, 0, 0, 3'b001, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, '0);
    add(0, 0, 1, 8, 3, 7, 0, 3'b001, 1, 9, 2, 0, 0, 3'b001, 0, 0, 1, bm(7));
    add(0, 0, 1, 7, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, bm(7));
    add(0, 0, 1, 7, 2, 0, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, bm(7));
    idle(0, bm(7));
    idle(0, bm(7));
    idle(0, '0);
    // flush with three registers in flight
    add(0, 0, 1, 12, 8, 0, 0, 3'b000, 1, 13, 8, 0, 0, 3'b000, 1, 1, 0, '0);
    add(0, 0, 1, 14, 8, 0, 0, 3'b000, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, bm(12, 13));
    add(0, 1, 1, 15, 3, 12, 0, 3'b001, 1, 16, 2, 13, 0, 3'b001, 0, 0, 1, bm(12, 13, 14));
    add(0, 0, 1, 15, 3, 0, 12, 3'b100, 1, 16, 2, 14, 0, 3'b001, 1, 1, 0, '0);
    // unused busy sources ignored; odd rb busy stalls odd only
    add(0, 0, 1, 0, 0, 15, 16, 3'b000, 1, 17, 1, 0, 15, 3'b010, 1, 0, 1, bm(15, 16));
    // reset mid-flight
    add(1, 0, 1, 18, 2, 0, 0, 3'b000, 1, 19, 2, 0, 0, 3'b000, 0, 0, 0, '0);
    idle(0, '0);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk("ev_issue", i, 128'(ifc.ev_issue), 128'(tv[i].xe));
      chk("od_issue", i, 128'(ifc.od_issue), 128'(tv[i].xo));
      chk("stall", i, 128'(ifc.stall), 128'(tv[i].xs));
      chk("busy_vec", i, ifc.busy_vec, tv[i].xb);
    end
    // maximum latency: dependent waits exactly 15 cycles
    v = tv[tv.size()-1];
    v.evv = 1; v.ert = 30; v.elat = 15;
    @(negedge clk);
    drive(v);
    #1;
    chk("max_lat_issue", 0, 128'(ifc.ev_issue), 128'(1));
    v.ert = 31; v.elat = 0; v.era = 30; v.euse = 3'b001;
    @(negedge clk);
    drive(v);
    #1;
    waits = 0;
    while (!ifc.ev_issue && waits < 40) begin
      waits++;
      @(negedge clk);
      #1;
    end
    chk("max_lat_wait", 0, 128'(waits), 128'(15));
    chk("max_lat_busy", 0, ifc.busy_vec, '0);
    // simultaneous flush and reset behaves as reset
    v.ert = 40; v.elat = 4; v.euse = 3'b000;
    @(negedge clk);
    drive(v);
    #1;
    chk("pre_fr_issue", 0, 128'(ifc.ev_issue), 128'(1));
    v.r = 1; v.f = 1;
    @(negedge clk);
    drive(v);
    #1;
    chk("fr_issue", 0, 128'(ifc.ev_issue), 128'(0));
    chk("fr_stall", 0, 128'(ifc.stall), 128'(0));
    v.r = 0; v.f = 0; v.evv = 0;
    @(negedge clk);
    drive(v);
    #1;
    chk("fr_busy", 0, ifc.busy_vec, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
